// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: forwarding, load-use and
// PC-write hazards, a memory-wait freeze FSM with timeout error, stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [1:0]       fsm_state
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           mem_stall;
  logic           ldr_stall;
  logic           pc_pend;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) MemErr <= 1'b1;
    end
  end

  // wait_cnt holds the number of unready stall cycles already spent in this wait
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_stall    = 1'b0;
    case (state)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall    = 1'b1;
          state_nxt    = WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = wait_cnt + WCW'(1);
          if (wait_cnt_nxt == WCW'(MEM_TIMEOUT)) state_nxt = ERR;
        end
      end
      ERR: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (RegWriteM && (ra == WA3M))      return 2'b10;
    else if (RegWriteW && (ra == WA3W)) return 2'b01;
    else                                return 2'b00;
  endfunction

  assign ldr_stall = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
  assign pc_pend   = PCSrcD || PCSrcE || PCSrcM;

  // Reset bubbles every register; a memory stall freezes the pipe and overrides other hazards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (!reset) begin
      ForwardAE = fwd_sel(RA1E);
      ForwardBE = fwd_sel(RA2E);
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end else begin
        StallF = ldr_stall || pc_pend;
        StallD = ldr_stall;
        FlushD = pc_pend || PCSrcW || BranchTakenE;
        FlushE = ldr_stall || BranchTakenE;
        FlushW = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then randomized cycles, all
// checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int MT    = 4;
  localparam int CW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic          RegWriteM, RegWriteW, MemtoRegE;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic          MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic          MemErr;
  logic [CW-1:0] StallCount;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_run;
  bit m_err;
  int m_cnt;
  // expected outputs for the current cycle
  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount), .fsm_state(fsm_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [3:0] ra);
    logic [1:0] r;
    r = 2'b00;
    if (RegWriteW && ra == WA3W) r = 2'b01;
    if (RegWriteM && ra == WA3M) r = 2'b10;
    return r;
  endfunction

  task automatic model_outputs();
    bit ldr, pc, ms;
    ldr = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
    pc  = PCSrcD || PCSrcE || PCSrcM;
    // frozen while in error, or while the access in M (new or ongoing) is unready
    ms  = m_err || (!MemReadyM && (m_run > 0 || MemReqM));
    if (reset) begin
      {e_fa, e_fb} = 4'b0;
      {e_sf, e_sd, e_se, e_sm} = 4'b0;
      {e_fd, e_fe, e_fw} = 3'b111;
    end else begin
      e_fa = model_fwd(RA1E);
      e_fb = model_fwd(RA2E);
      e_sf = ms || ldr || pc;
      e_sd = ms || ldr;
      e_se = ms;
      e_sm = ms;
      e_fd = !ms && (pc || PCSrcW || BranchTakenE);
      e_fe = !ms && (ldr || BranchTakenE);
      e_fw = ms;
    end
  endtask

  task automatic check_all(input string tag);
    model_outputs();
    chk({tag, ".fa"}, ForwardAE, e_fa);
    chk({tag, ".fb"}, ForwardBE, e_fb);
    chk({tag, ".sf"}, StallF, e_sf);
    chk({tag, ".sd"}, StallD, e_sd);
    chk({tag, ".se"}, StallE, e_se);
    chk({tag, ".sm"}, StallM, e_sm);
    chk({tag, ".fd"}, FlushD, e_fd);
    chk({tag, ".fe"}, FlushE, e_fe);
    chk({tag, ".fw"}, FlushW, e_fw);
    chk({tag, ".err"}, MemErr, m_err);
    chk({tag, ".cnt"}, StallCount, m_cnt);
  endtask

  task automatic advance();
    bit ms;
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_err = 0; m_cnt = 0;
    end else begin
      ms = m_err || (!MemReadyM && (m_run > 0 || MemReqM));
      if (!m_err) begin
        if (ms) begin
          m_run++;
          if (m_run == MT) m_err = 1;
        end else begin
          m_run = 0;
        end
      end
      if (e_sf && m_cnt < CMAX) m_cnt++;
    end
    #1;
  endtask

  task automatic settle(input string tag);
    #4;
    check_all(tag);
  endtask

  task automatic step(input string tag);
    settle(tag);
    advance();
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E} = {4'd1, 4'd2, 4'd3, 4'd5};
    {WA3E, WA3M, WA3W} = {4'd10, 4'd11, 4'd12};
    {RegWriteM, RegWriteW, MemtoRegE} = 3'b0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = 5'b0;
    MemReqM = 1'b0;
    MemReadyM = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_run = 0; m_err = 0; m_cnt = 0;
    #1;
    check_all("rst");
    advance();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    m_run = 0; m_err = 0; m_cnt = 0;
    #1;
    check_all("por");
    chk("por_flushd", FlushD, 1'b1);
    advance();
    reset = 1'b0;

    // load-use, then forwarding of the load now in M
    MemtoRegE = 1'b1; WA3E = 4'd4; RA1D = 4'd4;
    settle("lu0");
    chk("lu_stallf", StallF, 1'b1);
    chk("lu_flushe", FlushE, 1'b1);
    advance();
    MemtoRegE = 1'b0; WA3E = 4'd10; RA1D = 4'd1;
    RegWriteM = 1'b1; WA3M = 4'd4; RA1E = 4'd4;
    settle("lu1");
    chk("lu_fwd_a", ForwardAE, 2'b10);
    advance();

    // forward priority
    clear_inputs();
    RegWriteM = 1'b1; RegWriteW = 1'b1; WA3M = 4'd7; WA3W = 4'd7; RA2E = 4'd7;
    settle("fp0");
    chk("fp_m", ForwardBE, 2'b10);
    advance();
    RegWriteM = 1'b0;
    settle("fp1");
    chk("fp_w", ForwardBE, 2'b01);
    advance();
    RA2E = 4'd8;
    step("fp2");

    // memory wait of 3 cycles
    clear_inputs();
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle("mw");
      chk("mw_stallm", StallM, 1'b1);
      advance();
    end
    MemReadyM = 1'b1;
    settle("mw_rdy");
    chk("mw_rdy_stallf", StallF, 1'b0);
    advance();
    MemReqM = 1'b0;
    settle("mw_done");
    chk("mw_count", StallCount, 2'd3);
    advance();

    // branch under memory stall, then released
    BranchTakenE = 1'b1;
    step("br0");
    MemReqM = 1'b1; MemReadyM = 1'b0;
    settle("br_ms");
    chk("br_ms_flushd", FlushD, 1'b0);
    advance();
    MemReadyM = 1'b1;
    settle("br_rdy");
    chk("br_rdy_flushe", FlushE, 1'b1);
    advance();
    clear_inputs();

    // PC write travelling D->W
    PCSrcD = 1'b1; step("pc_d");
    PCSrcD = 1'b0; PCSrcE = 1'b1; step("pc_e");
    PCSrcE = 1'b0; PCSrcM = 1'b1; step("pc_m");
    PCSrcM = 1'b0; PCSrcW = 1'b1;
    settle("pc_w");
    chk("pc_w_flushd", FlushD, 1'b1);
    advance();
    PCSrcW = 1'b0;
    step("pc_end");

    // memory timeout into ERR, ready ignored, async reset clears
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < MT; i++) step("to");
    settle("to_err");
    chk("to_memerr", MemErr, 1'b1);
    advance();
    MemReadyM = 1'b1; MemReqM = 1'b0;
    settle("to_rdy");
    chk("to_rdy_stallf", StallF, 1'b1);
    #2;
    reset = 1'b1;
    m_run = 0; m_err = 0; m_cnt = 0;
    #1;
    check_all("to_arst");
    chk("to_arst_err", MemErr, 1'b0);
    chk("to_arst_stalle", StallE, 1'b0);
    advance();
    reset = 1'b0;

    // randomized cycles
    for (int n = 0; n < 400; n++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MemReqM = 1'($urandom_range(0, 1));
      MemReadyM = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) do_reset();
      else step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
